ecc_operand_streamer: RTL and testbench

Host-side companion to the ECC scalar-multiply core. It takes a full request (curve a, prime, Px, Py, key k) as parallel SIZE-bit words and serialises it onto the core's 4-bit nibble input bus, with a start pulse. It then waits for the core's done strobe, captures the 32-bit kP result pair, and holds it for the host under a valid/ready handshake.

---
 rtl/ecc_operand_streamer.sv | 194 +++++++++++++++++++
 tb/tb_ecc_operand_streamer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_operand_streamer.sv
// ecc_operand_streamer
//   Host-side front end for the ECC scalar-multiply core. A request (curve a,
//   prime, Px, Py, key k) is latched as parallel SIZE-bit words and serialised
//   MSB nibble first onto the core's 4-bit buses, with o_start on beat 0. The
//   block then waits for i_core_done, captures (kPx, kPy) and presents them to
//   the host under a valid/ready handshake.
//
//   Optional build macro: ECC_TIMEOUT_EN
//     When defined, a wait counter aborts WAIT after TIMEOUT cycles without
//     i_core_done and raises the sticky o_timeout flag. When undefined, WAIT
//     is unbounded and o_timeout is tied low.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid / o_ready            host request handshake (o_ready only in IDLE)
//   i_a,i_prime,i_px,i_py,i_k    request operands, sampled on accept
//   o_start                      one-cycle start pulse, coincides with beat 0
//   o_a,o_prime,o_px,o_py,o_k    nibble streams to the core (0 outside SEND)
//   i_core_done,i_core_x/y       core completion strobe and result
//   o_res_valid,o_res_x/y        captured result, held in HOLD
//   i_res_ready                  host consumes the result
//   o_busy                       high in every state except IDLE
//   o_timeout                    sticky abort flag
module ecc_operand_streamer #(
   parameter int SIZE    = 32,
   parameter int NIBBLES = SIZE / 4,
   parameter int TIMEOUT = 15000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [SIZE-1:0] i_a,
   input  logic [SIZE-1:0] i_prime,
   input  logic [SIZE-1:0] i_px,
   input  logic [SIZE-1:0] i_py,
   input  logic [SIZE-1:0] i_k,
   output logic            o_start,
   output logic [3:0]      o_a,
   output logic [3:0]      o_prime,
   output logic [3:0]      o_px,
   output logic [3:0]      o_py,
   output logic [3:0]      o_k,
   input  logic            i_core_done,
   input  logic [SIZE-1:0] i_core_x,
   input  logic [SIZE-1:0] i_core_y,
   output logic            o_res_valid,
   output logic [SIZE-1:0] o_res_x,
   output logic [SIZE-1:0] o_res_y,
   input  logic            i_res_ready,
   output logic            o_busy,
   output logic            o_timeout
);

   localparam int BW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_t;

   state_t state, state_nx;

   // Operand shift registers, index 0..4 = a, prime, px, py, k.
   logic [4:0][SIZE-1:0] sh;
   logic [BW-1:0]        beat;
   logic [SIZE-1:0]      res_x, res_y;

   logic accept;
   logic capture;
   logic last_beat;

   assign last_beat = (beat == BW'(NIBBLES - 1));

`ifdef ECC_TIMEOUT_EN
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WCW-1:0] wait_cnt;
   logic           wait_expire;
   logic           timeout_fire;
   logic           timeout_q;

   assign wait_expire = (wait_cnt == WCW'(TIMEOUT - 1));
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next state and handshake strobes
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
`ifdef ECC_TIMEOUT_EN
      timeout_fire = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (i_valid) begin
               accept   = 1'b1;
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            if (last_beat) state_nx = S_WAIT;
         end
         S_WAIT: begin
            // A done on the same cycle as expiry still wins.
            if (i_core_done) begin
               capture  = 1'b1;
               state_nx = S_HOLD;
            end
`ifdef ECC_TIMEOUT_EN
            else if (wait_expire) begin
               timeout_fire = 1'b1;
               state_nx     = S_IDLE;
            end
`endif
         end
         S_HOLD: begin
            if (i_res_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand serialiser and result capture
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sh    <= '0;
         beat  <= '0;
         res_x <= '0;
         res_y <= '0;
      end else begin
         if (accept) begin
            sh[0] <= i_a;
            sh[1] <= i_prime;
            sh[2] <= i_px;
            sh[3] <= i_py;
            sh[4] <= i_k;
            beat  <= '0;
         end else if (state == S_SEND) begin
            for (int i = 0; i < 5; i++) sh[i] <= sh[i] << 4;
            beat <= beat + 1'b1;
         end
         if (capture) begin
            res_x <= i_core_x;
            res_y <= i_core_y;
         end
      end
   end

`ifdef ECC_TIMEOUT_EN
   // Counter runs only while waiting; it is held at zero elsewhere so every
   // WAIT entry starts a fresh TIMEOUT window.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         else                 wait_cnt <= '0;
         if (accept)            timeout_q <= 1'b0;
         else if (timeout_fire) timeout_q <= 1'b1;
      end
   end
   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   // Outputs
   always_comb begin
      o_ready     = (state == S_IDLE);
      o_busy      = (state != S_IDLE);
      o_res_valid = (state == S_HOLD);
      o_res_x     = res_x;
      o_res_y     = res_y;
      o_start     = 1'b0;
      o_a         = 4'h0;
      o_prime     = 4'h0;
      o_px        = 4'h0;
      o_py        = 4'h0;
      o_k         = 4'h0;
      if (state == S_SEND) begin
         o_start = (beat == '0);
         o_a     = sh[0][SIZE-1 -: 4];
         o_prime = sh[1][SIZE-1 -: 4];
         o_px    = sh[2][SIZE-1 -: 4];
         o_py    = sh[3][SIZE-1 -: 4];
         o_k     = sh[4][SIZE-1 -: 4];
      end
   end

endmodule

// File: tb/tb_ecc_operand_streamer.sv
// Scoreboard bench for ecc_operand_streamer. Stimulus pushes expected nibble
// streams and results into queues; a negedge monitor pops and compares.
module tb_ecc_operand_streamer;

   localparam int SIZE    = 32;
   localparam int NIB     = SIZE / 4;
   localparam int TIMEOUT = 16;

   typedef logic [4:0][SIZE-1:0] ops_t;
   typedef struct { ops_t op; int cyc; } req_t;
   typedef struct { logic [SIZE-1:0] x; logic [SIZE-1:0] y; int cyc; } res_t;

   logic            i_clk, i_rst, i_valid, o_ready, o_start;
   logic [SIZE-1:0] i_a, i_prime, i_px, i_py, i_k;
   logic [3:0]      o_a, o_prime, o_px, o_py, o_k;
   logic            i_core_done, o_res_valid, i_res_ready, o_busy, o_timeout;
   logic [SIZE-1:0] i_core_x, i_core_y, o_res_x, o_res_y;

   ecc_operand_streamer #(.SIZE(SIZE), .NIBBLES(NIB), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_prime(i_prime), .i_px(i_px), .i_py(i_py), .i_k(i_k),
      .o_start(o_start), .o_a(o_a), .o_prime(o_prime), .o_px(o_px),
      .o_py(o_py), .o_k(o_k), .i_core_done(i_core_done),
      .i_core_x(i_core_x), .i_core_y(i_core_y), .o_res_valid(o_res_valid),
      .o_res_x(o_res_x), .o_res_y(o_res_y), .i_res_ready(i_res_ready),
      .o_busy(o_busy), .o_timeout(o_timeout));

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   mon_en = 0;
   req_t req_q[$];
   res_t res_q[$];

   initial begin
      i_clk = 0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: nibble j of a word is bits [SIZE-1-4j -: 4], MSB nibble first.
   function automatic logic [19:0] exp_beat(input ops_t op, input int j);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < 5; i++)
         r[19-4*i -: 4] = 4'((op[i] >> (SIZE - 4*(j+1))) & 32'hF);
      return r;
   endfunction

   // ---------------- monitor ----------------
   int              beat_idx = -1;
   req_t            cur;
   bit              prev_valid = 0;
   logic [SIZE-1:0] held_x, held_y;

   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_start) begin
            chk("start_overlap", (beat_idx != -1), 0);
            if (req_q.size() == 0) chk("unexpected_start", 1, 0);
            else begin
               cur = req_q.pop_front();
               chk("start_cycle", cyc, cur.cyc);
               beat_idx = 0;
            end
         end
         if (beat_idx >= 0) begin
            chk($sformatf("beat%0d_nibbles", beat_idx),
                {o_a, o_prime, o_px, o_py, o_k}, exp_beat(cur.op, beat_idx));
            beat_idx++;
            if (beat_idx == NIB || i_rst) beat_idx = -1;
         end else begin
            chk("idle_nibbles_zero", {o_a, o_prime, o_px, o_py, o_k}, 0);
         end
         if (o_res_valid && !prev_valid) begin
            if (res_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               res_t r;
               r = res_q.pop_front();
               chk("res_cycle", cyc, r.cyc);
               chk("res_x", o_res_x, r.x);
               chk("res_y", o_res_y, r.y);
               held_x = r.x;
               held_y = r.y;
            end
         end else if (o_res_valid) begin
            chk("res_x_stable", o_res_x, held_x);
            chk("res_y_stable", o_res_y, held_y);
         end
         prev_valid = o_res_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic ops_t rnd_ops();
      ops_t o;
      for (int i = 0; i < 5; i++) o[i] = $urandom;
      return o;
   endfunction

   // Caller guarantees the DUT is idle; accept happens at the next edge.
   task automatic send_req(input ops_t op);
      req_t r;
      i_a = op[0]; i_prime = op[1]; i_px = op[2]; i_py = op[3]; i_k = op[4];
      i_valid = 1;
      tick();
      r.op = op;
      r.cyc = cyc;
      req_q.push_back(r);
      i_valid = 0;
   endtask

   task automatic done_cap(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
      res_t r;
      i_core_x = x; i_core_y = y; i_core_done = 1;
      tick();
      r.x = x; r.y = y; r.cyc = cyc;
      res_q.push_back(r);
      i_core_done = 0;
   endtask

   task automatic release_res();
      i_res_ready = 1;
      tick();
      i_res_ready = 0;
      chk("release_valid_low", o_res_valid, 0);
      chk("release_ready_high", o_ready, 1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      ops_t op, op2;
      i_rst = 1; i_valid = 0; i_core_done = 0; i_res_ready = 0;
      i_a = 0; i_prime = 0; i_px = 0; i_py = 0; i_k = 0;
      i_core_x = 0; i_core_y = 0;
      ticks(2);
      i_rst = 0;
      chk("rst_ready", o_ready, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_start", o_start, 0);
      chk("rst_res_valid", o_res_valid, 0);
      chk("rst_res_x", o_res_x, 0);
      chk("rst_timeout", o_timeout, 0);
      mon_en = 1;

      // Directed request: prime 0x61 streams 0,0,0,0,0,0,6,1.
      op[0] = 32'h2; op[1] = 32'h61; op[2] = 32'h3; op[3] = 32'h6; op[4] = 32'hA;
      send_req(op);
      chk("t1_start", o_start, 1);
      for (int j = 0; j < NIB; j++) begin
         chk("t1_ready_low", o_ready, 0);
         tick();
      end
      chk("t1_wait_start_low", o_start, 0);
      chk("t1_wait_busy", o_busy, 1);
      done_cap(32'h3A, 32'h50);
      chk("t2_valid", o_res_valid, 1);
      // Hold 5 cycles; a stray done in HOLD must not disturb the result.
      for (int j = 0; j < 5; j++) begin
         i_core_done = (j == 2); i_core_x = 32'hDEAD; i_core_y = 32'hBEEF;
         tick();
         chk("t2_hold_x", o_res_x, 32'h3A);
         chk("t2_ready_low", o_ready, 0);
      end
      i_core_done = 0;
      release_res();
      chk("t2_res_kept", o_res_y, 32'h50);

      // Done during beat 3 and the last beat is ignored.
      send_req(rnd_ops());
      ticks(3);
      i_core_done = 1; tick(); i_core_done = 0;
      ticks(3);
      i_core_done = 1; tick(); i_core_done = 0;
      ticks(3);
      chk("t3_no_capture", o_res_valid, 0);
      chk("t3_still_busy", o_busy, 1);
      chk("t3_no_timeout", o_timeout, 0);
      done_cap(32'h1234, 32'h5678);
      release_res();

      // Operand change after accept, i_valid in WAIT, valid+ready in HOLD.
      op = rnd_ops();
      send_req(op);
      tick();
      i_a = '1;
      ticks(NIB - 1);
      i_valid = 1; i_res_ready = 1;
      ticks(3);
      i_valid = 0; i_res_ready = 0;
      chk("t4_wait_busy", o_busy, 1);
      done_cap(32'hAA55, 32'h55AA);
      op2 = rnd_ops();
      i_a = op2[0]; i_prime = op2[1]; i_px = op2[2]; i_py = op2[3]; i_k = op2[4];
      i_valid = 1; i_res_ready = 1;
      tick();
      i_res_ready = 0;
      chk("t4_exit_ready", o_ready, 1);
      chk("t4_exit_start", o_start, 0);
      send_req(op2);
      ticks(NIB);
      done_cap(32'h1, 32'h2);
      release_res();

      // Reset during beat 4 aborts the stream.
      send_req(rnd_ops());
      ticks(4);
      i_rst = 1; tick(); i_rst = 0;
      chk("t5_nibbles", {o_a, o_prime, o_px, o_py, o_k}, 0);
      chk("t5_start", o_start, 0);
      chk("t5_ready", o_ready, 1);
      chk("t5_res_valid", o_res_valid, 0);
      chk("t5_res_x", o_res_x, 0);
      send_req(rnd_ops());
      ticks(NIB);
      done_cap($urandom, $urandom);
      release_res();

`ifdef ECC_TIMEOUT_EN
      send_req(rnd_ops());
      ticks(NIB + TIMEOUT - 1);
      chk("t6_still_wait", o_ready, 0);
      tick();
      chk("t6_idle", o_ready, 1);
      chk("t6_timeout", o_timeout, 1);
      chk("t6_no_valid", o_res_valid, 0);
      send_req(rnd_ops());
      chk("t6_timeout_clr", o_timeout, 0);
      ticks(NIB);
      done_cap(32'h77, 32'h88);
      release_res();
`endif

      // Randomised traffic with stray done/ready during SEND.
      for (int it = 0; it < 20; it++) begin
         send_req(rnd_ops());
         for (int j = 0; j < NIB; j++) begin
            i_core_done = ($urandom_range(0, 3) == 0);
            i_res_ready = ($urandom_range(0, 1) == 0);
            i_valid     = ($urandom_range(0, 1) == 0);
            tick();
         end
         i_core_done = 0; i_res_ready = 0; i_valid = 0;
         ticks($urandom_range(0, 4));
         done_cap($urandom, $urandom);
         ticks($urandom_range(0, 3));
         release_res();
      end

      ticks(3);
      chk("end_req_q_empty", req_q.size(), 0);
      chk("end_res_q_empty", res_q.size(), 0);
      chk("end_stream_closed", (beat_idx == -1), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
